// File: rtl/cd_host_requester.sv
`default_nettype none
// ============================================================================
// Module   : cd_host_requester
// Purpose  : Host-side requester for a compressor/decompressor block. It
//            accepts one request at a time, issues it for a single cycle,
//            waits (with timeout) for the block's response, then returns a
//            status/result through a valid/ready handshake. Saturating
//            completion counters track OK, error and timeout outcomes.
// Revision : 1.0 - initial release
// ============================================================================
module cd_host_requester #(
  parameter int DATA_W  = 8,
  parameter int CMP_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_result,
  output logic [1:0]        command,
  output logic [DATA_W-1:0] data_in,
  output logic [CMP_W-1:0]  compressed_in,
  input  logic [CMP_W-1:0]  compressed_out,
  input  logic [DATA_W-1:0] decompressed_out,
  input  logic [1:0]        response,
  output logic [15:0]       cnt_ok,
  output logic [15:0]       cnt_err,
  output logic [15:0]       cnt_tmo
);

  // WAIT counter must be able to hold the value TIMEOUT itself.
  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_COMPRESS   = 2'b01;
  localparam logic [1:0] OP_DECOMPRESS = 2'b10;

  localparam logic [1:0] RSP_NONE    = 2'b00;
  localparam logic [1:0] RSP_VALID   = 2'b01;
  localparam logic [1:0] RSP_ERROR   = 2'b10;
  localparam logic [1:0] RSP_INVALID = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DUT_ERR = 2'b01;
  localparam logic [1:0] ST_INVALID = 2'b10;
  localparam logic [1:0] ST_TMO     = 2'b11;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_data;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [1:0]        r_status;
  logic [DATA_W-1:0] r_result;
  logic [15:0]       r_cnt_ok;
  logic [15:0]       r_cnt_err;
  logic [15:0]       r_cnt_tmo;

  logic              w_wait_expired;
  logic              w_done_entry;
  logic [1:0]        w_status;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_cmp_ext;

  // WAIT cycles are numbered from 1, so the limit is reached when the count equals TIMEOUT.
  assign w_wait_expired = (r_wait_cnt == WCNT_W'(TIMEOUT));
  assign w_done_entry   = (r_state == S_WAIT) && (w_next_state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a real response wins over an expiring timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if ((response != RSP_NONE) || w_wait_expired) w_next_state = S_DONE;
      S_DONE:  if (rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the compressor only sees the request during ISSUE.
  always_comb begin
    req_ready     = (r_state == S_IDLE);
    rsp_valid     = (r_state == S_DONE);
    command       = 2'b00;
    data_in       = '0;
    compressed_in = '0;
    if (r_state == S_ISSUE) begin
      command       = r_op;
      data_in       = r_data;
      compressed_in = r_data[CMP_W-1:0];
    end
  end

  // Translate the compressor response into status/result (no response means timeout).
  always_comb begin
    w_cmp_ext              = '0;
    w_cmp_ext[CMP_W-1:0]   = compressed_out;
    w_status               = ST_TMO;
    w_result               = '0;
    case (response)
      RSP_VALID: begin
        w_status = ST_OK;
        case (r_op)
          OP_COMPRESS:   w_result = w_cmp_ext;
          OP_DECOMPRESS: w_result = decompressed_out;
          default:       w_result = '0;
        endcase
      end
      RSP_ERROR:   w_status = ST_DUT_ERR;
      RSP_INVALID: w_status = ST_INVALID;
      default:     w_status = ST_TMO;
    endcase
  end

  // Request capture, WAIT cycle counter and held response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op       <= 2'b00;
      r_data     <= '0;
      r_wait_cnt <= '0;
      r_status   <= ST_OK;
      r_result   <= '0;
    end else begin
      if ((r_state == S_IDLE) && req_valid) begin
        r_op   <= req_op;
        r_data <= req_data;
      end
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= WCNT_W'(1);
      end else if ((r_state == S_WAIT) && !w_wait_expired) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end
      if (w_done_entry) begin
        r_status <= w_status;
        r_result <= w_result;
      end
    end
  end

  // Saturating completion counters, bumped once on each entry into DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt_ok  <= '0;
      r_cnt_err <= '0;
      r_cnt_tmo <= '0;
    end else if (w_done_entry) begin
      case (w_status)
        ST_OK:   if (r_cnt_ok  != CNT_MAX) r_cnt_ok  <= r_cnt_ok  + 16'd1;
        ST_TMO:  if (r_cnt_tmo != CNT_MAX) r_cnt_tmo <= r_cnt_tmo + 16'd1;
        default: if (r_cnt_err != CNT_MAX) r_cnt_err <= r_cnt_err + 16'd1;
      endcase
    end
  end

  assign rsp_status = r_status;
  assign rsp_result = r_result;
  assign cnt_ok     = r_cnt_ok;
  assign cnt_err    = r_cnt_err;
  assign cnt_tmo    = r_cnt_tmo;

endmodule
`default_nettype wire

// File: tb/tb_cd_host_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_cd_host_requester
// Purpose  : Directed self-checking bench for cd_host_requester. The bench
//            plays the compressor by driving response/compressed_out/
//            decompressed_out directly at hand-chosen cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cd_host_requester;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_result;
  logic [1:0]  command;
  logic [7:0]  data_in;
  logic [3:0]  compressed_in;
  logic [3:0]  compressed_out;
  logic [7:0]  decompressed_out;
  logic [1:0]  response;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_err;
  logic [15:0] cnt_tmo;

  int n_chk;
  int n_fail;

  cd_host_requester #(
    .DATA_W  (8),
    .CMP_W   (4),
    .TIMEOUT (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_data         (req_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_status       (rsp_status),
    .rsp_result       (rsp_result),
    .command          (command),
    .data_in          (data_in),
    .compressed_in    (compressed_in),
    .compressed_out   (compressed_out),
    .decompressed_out (decompressed_out),
    .response         (response),
    .cnt_ok           (cnt_ok),
    .cnt_err          (cnt_err),
    .cnt_tmo          (cnt_tmo)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling/driving.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake one request from IDLE; returns while the DUT is in ISSUE.
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    req_op    = op;
    req_data  = data;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    reset            = 1'b0;
    req_valid        = 1'b0;
    req_op           = 2'b00;
    req_data         = 8'h00;
    rsp_ready        = 1'b1;
    compressed_out   = 4'h0;
    decompressed_out = 8'h00;
    response         = 2'b00;

    // ---- Reset state
    tick();
    tick();
    reset = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_status",    32'(rsp_status), 32'h0);
    chk("rst_result",    32'(rsp_result), 32'h0);
    chk("rst_command",   32'(command), 32'h0);
    chk("rst_data_in",   32'(data_in), 32'h0);
    chk("rst_cmp_in",    32'(compressed_in), 32'h0);
    chk("rst_cnt_ok",    32'(cnt_ok), 32'h0);

    // ---- COMPRESS A5, OK with 3 two cycles after ISSUE
    issue(2'b01, 8'hA5);
    chk("c_issue_cmd",   32'(command), 32'h1);
    chk("c_issue_data",  32'(data_in), 32'hA5);
    chk("c_issue_cin",   32'(compressed_in), 32'h5);
    chk("c_issue_ready", 32'(req_ready), 32'h0);
    tick();
    chk("c_wait_cmd",    32'(command), 32'h0);
    chk("c_wait_data",   32'(data_in), 32'h0);
    tick();
    response       = 2'b01;
    compressed_out = 4'h3;
    tick();
    chk("c_done_valid",  32'(rsp_valid), 32'h1);
    chk("c_done_status", 32'(rsp_status), 32'h0);
    chk("c_done_result", 32'(rsp_result), 32'h03);
    chk("c_cnt_ok",      32'(cnt_ok), 32'h1);
    response = 2'b00;
    tick();
    chk("c_idle_ready",  32'(req_ready), 32'h1);
    chk("c_idle_valid",  32'(rsp_valid), 32'h0);

    // ---- DECOMPRESS 03; an error response during ISSUE must be ignored
    issue(2'b10, 8'h03);
    chk("d_issue_cmd",   32'(command), 32'h2);
    chk("d_issue_cin",   32'(compressed_in), 32'h3);
    response = 2'b10;
    tick();
    response         = 2'b01;
    decompressed_out = 8'hA5;
    tick();
    chk("d_done_status", 32'(rsp_status), 32'h0);
    chk("d_done_result", 32'(rsp_result), 32'hA5);
    chk("d_cnt_ok",      32'(cnt_ok), 32'h2);
    chk("d_cnt_err",     32'(cnt_err), 32'h0);
    response = 2'b00;
    tick();

    // ---- Timeout after exactly 16 WAIT cycles
    compressed_out = 4'hF;
    issue(2'b01, 8'h5A);
    repeat (16) tick();
    chk("t_c16_valid",   32'(rsp_valid), 32'h0);
    tick();
    chk("t_done_valid",  32'(rsp_valid), 32'h1);
    chk("t_done_status", 32'(rsp_status), 32'h3);
    chk("t_done_result", 32'(rsp_result), 32'h0);
    chk("t_cnt_tmo",     32'(cnt_tmo), 32'h1);
    tick();

    // ---- Response on the 16th WAIT cycle beats the timeout
    issue(2'b01, 8'h5A);
    repeat (16) tick();
    compressed_out = 4'h9;
    response       = 2'b01;
    tick();
    chk("p_done_status", 32'(rsp_status), 32'h0);
    chk("p_done_result", 32'(rsp_result), 32'h09);
    chk("p_cnt_ok",      32'(cnt_ok), 32'h3);
    chk("p_cnt_tmo",     32'(cnt_tmo), 32'h1);
    response = 2'b00;
    tick();

    // ---- Error responses
    compressed_out = 4'h7;
    issue(2'b01, 8'h11);
    tick();
    response = 2'b10;
    tick();
    chk("e1_status",     32'(rsp_status), 32'h1);
    chk("e1_result",     32'(rsp_result), 32'h0);
    response = 2'b00;
    tick();
    issue(2'b10, 8'h22);
    tick();
    response = 2'b11;
    tick();
    chk("e2_status",     32'(rsp_status), 32'h2);
    chk("e2_result",     32'(rsp_result), 32'h0);
    chk("e_cnt_err",     32'(cnt_err), 32'h2);
    chk("e_cnt_ok",      32'(cnt_ok), 32'h3);
    response = 2'b00;
    tick();

    // ---- Back-pressure in DONE: outputs hold, stray responses ignored
    rsp_ready = 1'b0;
    issue(2'b01, 8'h11);
    tick();
    response       = 2'b01;
    compressed_out = 4'h6;
    tick();
    response = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("h_valid",  32'(rsp_valid), 32'h1);
      chk("h_status", 32'(rsp_status), 32'h0);
      chk("h_result", 32'(rsp_result), 32'h06);
      chk("h_ready",  32'(req_ready), 32'h0);
      response  = (i % 2 == 0) ? 2'b10 : 2'b00;
      req_valid = 1'b1;
      tick();
    end
    response  = 2'b00;
    req_valid = 1'b0;
    chk("h_valid_end",   32'(rsp_valid), 32'h1);
    chk("h_cnt_ok",      32'(cnt_ok), 32'h4);
    chk("h_cnt_err",     32'(cnt_err), 32'h2);
    rsp_ready = 1'b1;
    tick();
    chk("h_idle_ready",  32'(req_ready), 32'h1);
    chk("h_idle_valid",  32'(rsp_valid), 32'h0);

    // ---- Response while IDLE is ignored
    response = 2'b10;
    tick();
    response = 2'b00;
    chk("i_idle_ready",  32'(req_ready), 32'h1);
    chk("i_cnt_err",     32'(cnt_err), 32'h2);
    tick();

    // ---- Reserved op forwarded unchanged
    compressed_out = 4'h0;
    issue(2'b11, 8'h77);
    chk("r_issue_cmd",   32'(command), 32'h3);
    chk("r_issue_data",  32'(data_in), 32'h77);
    chk("r_issue_cin",   32'(compressed_in), 32'h7);
    tick();
    response = 2'b11;
    tick();
    chk("r_status",      32'(rsp_status), 32'h2);
    chk("r_cnt_err",     32'(cnt_err), 32'h3);
    response = 2'b00;
    tick();

    // ---- NOP with no response ends in timeout
    issue(2'b00, 8'h42);
    chk("n_issue_cmd",   32'(command), 32'h0);
    chk("n_issue_data",  32'(data_in), 32'h42);
    repeat (17) tick();
    chk("n_status",      32'(rsp_status), 32'h3);
    chk("n_cnt_tmo",     32'(cnt_tmo), 32'h2);
    tick();

    // ---- Reset during WAIT abandons the request and clears counters
    issue(2'b01, 8'h12);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("m_ready",       32'(req_ready), 32'h1);
    chk("m_valid",       32'(rsp_valid), 32'h0);
    chk("m_cnt_ok",      32'(cnt_ok), 32'h0);
    chk("m_cnt_err",     32'(cnt_err), 32'h0);
    chk("m_cnt_tmo",     32'(cnt_tmo), 32'h0);
    reset = 1'b1;
    response = 2'b01;
    tick();
    response = 2'b00;
    chk("m_post_valid",  32'(rsp_valid), 32'h0);
    chk("m_post_ready",  32'(req_ready), 32'h1);
    chk("m_post_cnt_ok", 32'(cnt_ok), 32'h0);

    // ---- Saturation: preload the OK counter just below its ceiling
    force dut.r_cnt_ok = 16'hFFFE;
    #1;
    release dut.r_cnt_ok;
    for (int k = 0; k < 2; k++) begin
      issue(2'b01, 8'h01);
      tick();
      response = 2'b01;
      tick();
      chk("s_cnt_ok",    32'(cnt_ok), 32'hFFFF);
      response = 2'b00;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
